// File: rtl/dual_port_ram_responder_pkg.sv
// ---------------------------------------------------------------------------
// dual_port_ram_responder_pkg
// Shared widths and the FSM state encoding for the dual-port cache RAM
// responder. DATA_W is the cache word width, DATA_ADDR_W the width of the
// word address the caches drive.
// ---------------------------------------------------------------------------
package dual_port_ram_responder_pkg;

  localparam int DATA_W      = 32;
  localparam int DATA_ADDR_W = 32;

  // IDLE: no owner; ACCESS: beat in flight; DONE: single completion cycle;
  // HOLD: atomic owner keeps the grant while it has nothing to issue.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/dual_port_ram_responder_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin grant selection, purely combinational.
//   i_req[1:0] : request from port 0 / port 1
//   i_rr_last  : port that owned the memory most recently
//   i_lock     : atomic lock active, grant pinned to i_owner
//   i_owner    : current owner
//   o_grant    : port index that should own the memory next
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_rr_last,
  input  logic       i_lock,
  input  logic       i_owner,
  output logic       o_grant
);

  // Lock wins outright; otherwise a lone requester wins and a tie goes to the
  // port that was not served last.
  always_comb begin
    o_grant = 1'b0;
    if (i_lock) begin
      o_grant = i_owner;
    end else begin
      case (i_req)
        2'b01:   o_grant = 1'b0;
        2'b10:   o_grant = 1'b1;
        2'b11:   o_grant = ~i_rr_last;
        default: o_grant = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/dual_port_ram_responder.sv
// ---------------------------------------------------------------------------
// dual_port_ram_responder
// Target end of the cache RAM protocol for two caches sharing one
// word-addressed array of 2**MEM_AW words.
//   clk, reset_n                 : clock, async active-low reset
//   pN_ram_addr/read/write/data_w: request from cache N (held until done)
//   pN_cache_atomic_i            : cache N wants to keep the memory
//   pN_ram_wait                  : stall to cache N (low only in its DONE)
//   pN_ram_data_r                : read data, held until next read on N
//   pN_arbiter_permit            : port N owns the memory
//   proto_err                    : sticky, read+write seen together
// ---------------------------------------------------------------------------
module dual_port_ram_responder
  import dual_port_ram_responder_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_ADDR_W-1:0] p0_ram_addr,
  input  logic [DATA_ADDR_W-1:0] p1_ram_addr,
  input  logic                   p0_ram_read,
  input  logic                   p1_ram_read,
  input  logic                   p0_ram_write,
  input  logic                   p1_ram_write,
  input  logic [DATA_W-1:0]      p0_ram_data_w,
  input  logic [DATA_W-1:0]      p1_ram_data_w,
  input  logic                   p0_cache_atomic_i,
  input  logic                   p1_cache_atomic_i,
  output logic                   p0_ram_wait,
  output logic                   p1_ram_wait,
  output logic [DATA_W-1:0]      p0_ram_data_r,
  output logic [DATA_W-1:0]      p1_ram_data_r,
  output logic                   p0_arbiter_permit,
  output logic                   p1_arbiter_permit,
  output logic                   proto_err
);

  localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

  state_e                  r_state;
  logic                    r_owner;
  logic                    r_rr_last;
  logic                    r_lock;
  logic [3:0]              r_cnt;
  logic [DATA_ADDR_W-1:0]  r_addr;
  logic                    r_rd;
  logic                    r_wr;
  logic [DATA_W-1:0]       r_wdata;
  logic [1:0]              r_permit;
  logic [DATA_W-1:0]       r_data_r0;
  logic [DATA_W-1:0]       r_data_r1;
  logic                    r_proto_err;
  logic [DATA_W-1:0]       r_mem [0:(2**MEM_AW)-1];

  logic [1:0]              w_req;
  logic                    w_grant;
  logic                    w_sel;
  logic                    w_sel_req;
  logic                    w_sel_rd;
  logic                    w_sel_wr;
  logic                    w_sel_atomic;
  logic [DATA_ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]       w_sel_wdata;
  logic                    w_new_beat;
  logic                    w_load;

  assign w_req = {p1_ram_read | p1_ram_write, p0_ram_read | p0_ram_write};

  rr_arbiter2 u_arb (
    .i_req     (w_req),
    .i_rr_last (r_rr_last),
    .i_lock    (r_lock),
    .i_owner   (r_owner),
    .o_grant   (w_grant)
  );

  // Route the port that is about to be served (IDLE) or is being served.
  always_comb begin
    w_sel = (r_state == ST_IDLE) ? w_grant : r_owner;
    if (w_sel == 1'b0) begin
      w_sel_req    = w_req[0];
      w_sel_rd     = p0_ram_read;
      w_sel_wr     = p0_ram_write;
      w_sel_atomic = p0_cache_atomic_i;
      w_sel_addr   = p0_ram_addr;
      w_sel_wdata  = p0_ram_data_w;
    end else begin
      w_sel_req    = w_req[1];
      w_sel_rd     = p1_ram_read;
      w_sel_wr     = p1_ram_write;
      w_sel_atomic = p1_cache_atomic_i;
      w_sel_addr   = p1_ram_addr;
      w_sel_wdata  = p1_ram_data_w;
    end
  end

  // In DONE the owner still shows the finished beat unless it has already
  // moved on; a different address or direction marks the next burst beat.
  // The full address is compared so an aliased address still counts as new.
  assign w_new_beat = w_sel_req &&
                      ((w_sel_addr != r_addr) || (w_sel_wr != r_wr));

  // Decide whether the beat registers capture the selected port this edge.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_IDLE:   w_load = |w_req;
      ST_ACCESS: w_load = 1'b0;
      ST_DONE:   w_load = w_new_beat;
      ST_HOLD:   w_load = w_sel_req;
      default:   w_load = 1'b0;
    endcase
  end

  // Control FSM: ownership, lock, latency count, registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b0;
      r_rr_last   <= 1'b1;
      r_lock      <= 1'b0;
      r_cnt       <= 4'd0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_wdata     <= '0;
      r_permit    <= 2'b00;
      r_data_r0   <= '0;
      r_data_r1   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state  <= ST_ACCESS;
            r_owner  <= w_grant;
            r_permit <= w_grant ? 2'b10 : 2'b01;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_DONE;
            if (r_rd) begin
              if (r_owner) begin
                r_data_r1 <= r_mem[r_addr[MEM_AW-1:0]];
              end else begin
                r_data_r0 <= r_mem[r_addr[MEM_AW-1:0]];
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (w_new_beat) begin
            r_state <= ST_ACCESS;
          end else if (w_sel_atomic) begin
            r_lock  <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_lock    <= 1'b0;
            r_rr_last <= r_owner;
            r_permit  <= 2'b00;
            r_state   <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (w_sel_req) begin
            r_state <= ST_ACCESS;
          end else if (!w_sel_atomic) begin
            r_lock    <= 1'b0;
            r_rr_last <= r_owner;
            r_permit  <= 2'b00;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_permit <= 2'b00;
          r_lock   <= 1'b0;
        end
      endcase

      // A simultaneous read+write is executed as a write and flagged.
      if (w_load) begin
        r_addr  <= w_sel_addr;
        r_rd    <= w_sel_rd & ~w_sel_wr;
        r_wr    <= w_sel_wr;
        r_wdata <= w_sel_wdata;
        r_cnt   <= w_sel_wr ? WR_CNT : RD_CNT;
        if (w_sel_rd && w_sel_wr) begin
          r_proto_err <= 1'b1;
        end
      end
    end
  end

  // Commit a write on the edge leaving ACCESS; the array is never reset, so
  // a reset before this edge simply drops the write.
  always_ff @(posedge clk) begin
    if ((r_state == ST_ACCESS) && (r_cnt == 4'd0) && r_wr) begin
      r_mem[r_addr[MEM_AW-1:0]] <= r_wdata;
    end
  end

  // Wait is low only in the owner's DONE cycle, and forced low in reset.
  assign p0_ram_wait = reset_n & w_req[0] &
                       ~((r_state == ST_DONE) && (r_owner == 1'b0));
  assign p1_ram_wait = reset_n & w_req[1] &
                       ~((r_state == ST_DONE) && (r_owner == 1'b1));

  assign p0_ram_data_r     = r_data_r0;
  assign p1_ram_data_r     = r_data_r1;
  assign p0_arbiter_permit = r_permit[0];
  assign p1_arbiter_permit = r_permit[1];
  assign proto_err         = r_proto_err;

endmodule
